div: RTL and testbench



---
 rtl/div.sv | 59 +++++
 tb/tb_div.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// div: sequential signed restoring divider giving the MIPS DIV quotient on LO and remainder on HI
module div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             div_start,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_end,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, bmag;
  logic [WIDTH:0] shifted, trial;
  logic sign_q, sign_r;
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial = shifted - {1'b0, bmag};
    state_n = div_start ? (B == '0 ? DONE : CALC)
            : state == CALC ? (cnt == CW'(1) ? FIX : CALC)
            : state == FIX ? DONE : state;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      {HI, LO, div_end, div_zero} <= '0;
      {rem, quo, bmag, sign_q, sign_r} <= '0;
      cnt <= '0;
    end else if (div_start) begin
      sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
      sign_r <= A[WIDTH-1];
      quo <= A[WIDTH-1] ? -A : A;
      bmag <= B[WIDTH-1] ? -B : B;
      rem <= '0;
      cnt <= CW'(WIDTH);
      div_end <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == CALC) begin
      rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      LO <= sign_q ? -quo : quo;
      HI <= sign_r ? -rem : rem;
      div_end <= 1'b1;
    end else if (state == DONE && bmag == '0) begin
      div_end <= 1'b1;
      div_zero <= 1'b1;
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for the signed sequential divider
module tb_div;
  logic clock, reset, div_start, div_end, div_zero;
  logic [31:0] A, B, HI, LO;
  logic [64:0] sb[$];
  logic [64:0] exp_v;
  logic [31:0] m_hi, m_lo;
  int n_vec, n_err, lat;

  div #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .A(A), .B(B), .div_start(div_start),
    .HI(HI), .LO(LO), .div_end(div_end), .div_zero(div_zero));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      sb.push_back({1'b1, m_hi, m_lo});
    end else begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
      m_hi = r;
      m_lo = q;
      sb.push_back({1'b0, r, q});
    end
    A = a;
    B = b;
    div_start = 1'b1;
    @(negedge clock);
    div_start = 1'b0;
  endtask

  task automatic wait_end(output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      A = $urandom;
      B = $urandom;
      if (div_end) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_hi = 0;
    m_lo = 0;
    n_vec++;
    if ({HI, LO, div_end, div_zero} !== 66'd0) begin
      n_err++;
      $display("FAIL reset: HI=%h LO=%h end=%b zero=%b, need all zero", HI, LO, div_end, div_zero);
    end
  endtask

  task automatic test_signs;
    logic [31:0] va[4] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C};
    logic [31:0] vb[4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      wait_end(lat);
      exp_v = sb.pop_front();
      n_vec++;
      if (lat !== 33) begin
        n_err++;
        $display("FAIL signs[%0d] latency: got %0d need 33", i, lat);
      end
      n_vec++;
      if ({div_zero, HI, LO} !== exp_v) begin
        n_err++;
        $display("FAIL signs[%0d] result: zero=%b HI=%h LO=%h need %h", i, div_zero, HI, LO, exp_v);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] va[3] = '{32'h8000_0000, 32'h8000_0000, 32'd5};
    logic [31:0] vb[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i]);
      wait_end(lat);
      exp_v = sb.pop_front();
      n_vec++;
      if (lat !== 33 || {div_zero, HI, LO} !== exp_v) begin
        n_err++;
        $display("FAIL overflow[%0d]: lat=%0d zero=%b HI=%h LO=%h need lat 33 %h", i, lat, div_zero, HI, LO, exp_v);
      end
    end
  endtask

  task automatic test_div_zero;
    start_op(32'd7, 32'd2);
    wait_end(lat);
    void'(sb.pop_front());
    start_op(32'd5, 32'd0);
    wait_end(lat);
    exp_v = sb.pop_front();
    n_vec++;
    if (lat !== 1) begin
      n_err++;
      $display("FAIL div_zero latency: got %0d need 1", lat);
    end
    n_vec++;
    if ({div_zero, HI, LO} !== exp_v || exp_v !== {1'b1, 32'd1, 32'd3}) begin
      n_err++;
      $display("FAIL div_zero result: zero=%b HI=%h LO=%h need %h", div_zero, HI, LO, exp_v);
    end
    repeat (3) @(negedge clock);
    n_vec++;
    if ({div_end, div_zero} !== 2'b11) begin
      n_err++;
      $display("FAIL div_zero hold: end=%b zero=%b need 11", div_end, div_zero);
    end
  endtask

  task automatic test_reset_mid;
    start_op(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    m_hi = 0;
    m_lo = 0;
    for (int i = 10; i <= 40; i++) begin
      n_vec++;
      if ({HI, LO, div_end} !== 65'd0) begin
        n_err++;
        $display("FAIL reset_mid k+%0d: HI=%h LO=%h end=%b need zeros", i, HI, LO, div_end);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_restart;
    start_op(32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    sb.delete();
    start_op(32'd9, 32'd4);
    wait_end(lat);
    exp_v = sb.pop_front();
    n_vec++;
    if (lat !== 33) begin
      n_err++;
      $display("FAIL restart latency: got %0d need 33", lat);
    end
    n_vec++;
    if ({div_zero, HI, LO} !== exp_v || exp_v !== {1'b0, 32'd1, 32'd2}) begin
      n_err++;
      $display("FAIL restart result: zero=%b HI=%h LO=%h need %h", div_zero, HI, LO, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 2 == 1) b = -b;
      start_op(a, b);
      wait_end(lat);
      exp_v = sb.pop_front();
      n_vec++;
      if (lat !== 33 || {div_zero, HI, LO} !== exp_v) begin
        n_err++;
        $display("FAIL b2b[%0d] %h/%h: lat=%0d zero=%b HI=%h LO=%h need lat 33 %h", i, a, b, lat, div_zero, HI, LO, exp_v);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    div_start = 1'b0;
    A = '0;
    B = '0;
    test_reset;
    test_signs;
    test_overflow;
    test_div_zero;
    test_reset_mid;
    test_restart;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
